aes_key_sched: RTL and testbench

Parametrised AES key-schedule engine for 128-, 192- and 256-bit keys. It replaces the 128-bit-only round-keyed expander. It computes the FIPS-197 expanded key one 32-bit word per cycle and delivers round keys 0..Nr in order over a valid/ready stream. It sits between the key input of `aes_top` and the cipher round datapath.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_sub_word.sv | 12 +
 rtl/aes_key_sched.sv | 191 +++++++++++++++++++
 tb/tb_aes_key_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and byte-level helpers for the AES key-schedule engine.
package aes_pkg;

    typedef logic [31:0] aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DRAIN  = 2'd2
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic int nk_of(input int key_size);
        return key_size / 32;
    endfunction

    function automatic int nr_of(input int key_size);
        return key_size / 32 + 6;
    endfunction

    // GF(2^8) multiply by x, reducing with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: S-box substitution of each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  aes_word_t word_i,
    output aes_word_t word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_sched.sv
// AES key-schedule engine: expands a 128/192/256-bit key one word per cycle
// and streams round keys 0..Nr over a valid/ready interface.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_SIZE = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_data,
    output logic         done
);

    localparam int NK = nk_of(KEY_SIZE);
    localparam int NR = nr_of(KEY_SIZE);
    localparam int NW = 4 * (NR + 1);

    if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
        $error("aes_key_sched: KEY_SIZE must be 128, 192 or 256");
    end

    ks_state_e    state_q, state_d;
    aes_word_t    win_q [NK];
    aes_word_t    win_d [NK];
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   j_q, j_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [95:0]  acc_q, acc_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]   rk_round_q, rk_round_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    aes_word_t    w_prev_s, w_old_s, sub_in_s, sub_out_s, w_new_s;
    logic         stall_s, hs_s;
    logic         key_unused_s;

    assign key_unused_s = ^key;
    assign w_prev_s     = win_q[NK-1];
    assign w_old_s      = win_q[0];
    assign sub_in_s     = (j_q == 3'd0) ? {w_prev_s[23:0], w_prev_s[31:24]} : w_prev_s;
    assign stall_s      = rk_valid_q && !rk_ready;
    assign hs_s         = rk_valid_q && rk_ready;

    aes_sub_word u_sub_word (
        .word_i (sub_in_s),
        .word_o (sub_out_s)
    );

    // Next expanded word. The window is rotated during the first Nk cycles,
    // so its oldest entry is the raw key word and afterwards w[i-Nk].
    always_comb begin
        if (idx_q < 6'(NK)) begin
            w_new_s = w_old_s;
        end else if (j_q == 3'd0) begin
            w_new_s = w_old_s ^ sub_out_s ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && j_q == 3'd4) begin
            w_new_s = w_old_s ^ sub_out_s;
        end else begin
            w_new_s = w_old_s ^ w_prev_s;
        end
    end

    // FSM next-state, word window, accumulator and output-register updates.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        idx_d      = idx_q;
        j_d        = j_q;
        rcon_d     = rcon_q;
        acc_d      = acc_q;
        rk_data_d  = rk_data_q;
        rk_round_d = rk_round_q;
        rk_valid_d = rk_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EXPAND;
                    busy_d  = 1'b1;
                    idx_d   = 6'd0;
                    j_d     = 3'd0;
                    rcon_d  = 8'h01;
                    for (int k = 0; k < NK; k++) begin
                        win_d[k] = key[KEY_SIZE-1-32*k -: 32];
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_EXPAND: begin
                if (!stall_s) begin
                    for (int k = 0; k < NK - 1; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[NK-1] = w_new_s;
                    idx_d = idx_q + 6'd1;
                    j_d   = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
                    if (idx_q >= 6'(NK) && j_q == 3'd0) begin
                        rcon_d = xtime(rcon_q);
                    end else begin
                        rcon_d = rcon_q;
                    end
                    case (idx_q[1:0])
                        2'd0:    acc_d[95:64] = w_new_s;
                        2'd1:    acc_d[63:32] = w_new_s;
                        2'd2:    acc_d[31:0]  = w_new_s;
                        default: acc_d        = acc_q;
                    endcase
                    if (idx_q[1:0] == 2'd3) begin
                        rk_data_d  = {acc_q, w_new_s};
                        rk_round_d = idx_q[5:2];
                        rk_valid_d = 1'b1;
                    end else if (hs_s) begin
                        rk_valid_d = 1'b0;
                    end else begin
                        rk_valid_d = rk_valid_q;
                    end
                    if (idx_q == 6'(NW - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_EXPAND;
                    end
                end else begin
                    state_d = ST_EXPAND;
                end
            end
            ST_DRAIN: begin
                if (hs_s) begin
                    rk_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                rk_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            for (int k = 0; k < NK; k++) begin
                win_q[k] <= 32'h00000000;
            end
            idx_q      <= 6'd0;
            j_q        <= 3'd0;
            rcon_q     <= 8'h01;
            acc_q      <= 96'h0;
            rk_data_q  <= 128'h0;
            rk_round_q <= 4'd0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            idx_q      <= idx_d;
            j_q        <= j_d;
            rcon_q     <= rcon_d;
            acc_q      <= acc_d;
            rk_data_q  <= rk_data_d;
            rk_round_q <= rk_round_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_round = rk_round_q;
    assign rk_data  = rk_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: known-answer vectors for all three key
// sizes plus randomized keys/backpressure against a GF(2^8)-level reference.
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start_c, ready_c;
    logic [255:0] key_c;
    int           sel;
    int           checks = 0;
    int           errors = 0;

    logic         b128, v128, dn128, b192, v192, dn192, b256, v256, dn256;
    logic [3:0]   r128, r192, r256;
    logic [127:0] d128, d192, d256;
    logic         cur_busy, cur_valid, cur_done;
    logic [3:0]   cur_round;
    logic [127:0] cur_data;

    logic [7:0]   sref [256];
    logic [31:0]  ref_w [60];
    logic [127:0] cap [15];

    always #5 clk = ~clk;

    aes_key_sched #(.KEY_SIZE(128)) u128 (
        .clk(clk), .reset_n(reset_n), .start(start_c && sel == 0), .key(key_c),
        .busy(b128), .rk_valid(v128), .rk_ready(ready_c && sel == 0),
        .rk_round(r128), .rk_data(d128), .done(dn128));
    aes_key_sched #(.KEY_SIZE(192)) u192 (
        .clk(clk), .reset_n(reset_n), .start(start_c && sel == 1), .key(key_c),
        .busy(b192), .rk_valid(v192), .rk_ready(ready_c && sel == 1),
        .rk_round(r192), .rk_data(d192), .done(dn192));
    aes_key_sched #(.KEY_SIZE(256)) u256 (
        .clk(clk), .reset_n(reset_n), .start(start_c && sel == 2), .key(key_c),
        .busy(b256), .rk_valid(v256), .rk_ready(ready_c && sel == 2),
        .rk_round(r256), .rk_data(d256), .done(dn256));

    assign cur_busy  = (sel == 0) ? b128  : (sel == 1) ? b192  : b256;
    assign cur_valid = (sel == 0) ? v128  : (sel == 1) ? v192  : v256;
    assign cur_done  = (sel == 0) ? dn128 : (sel == 1) ? dn192 : dn256;
    assign cur_round = (sel == 0) ? r128  : (sel == 1) ? r192  : r256;
    assign cur_data  = (sel == 0) ? d128  : (sel == 1) ? d192  : d256;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int m = 0; m < n; m++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            if (b != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(b));
            end
            sref[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sref[x[31:24]], sref[x[23:16]], sref[x[15:8]], sref[x[7:0]]};
    endfunction

    task automatic ref_expand(input int nk, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                ref_w[i] = k[32*nk-1-32*i -: 32];
            end else begin
                t = ref_w[i-1];
                if (i % nk == 0) begin
                    rc = 8'h01;
                    for (int e = 1; e < i / nk; e++) rc = gmul(rc, 8'h02);
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                ref_w[i] = ref_w[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one expansion on instance s, consuming keys with probability pct%.
    task automatic run_exp(input int s, input logic [255:0] k, input int pct, input int poke,
                           input bit hold, output int done_cyc, output int first_cyc,
                           output int stalls);
        int nk, nr, exp_r, cyc;
        bit stalled, fin;
        logic [127:0] pd;
        logic [3:0]   pr;
        nk = (s == 0) ? 4 : (s == 1) ? 6 : 8;
        nr = nk + 6;
        exp_r = 0; cyc = 0; stalled = 1'b0; fin = 1'b0;
        done_cyc = -1; first_cyc = -1; stalls = 0;
        pd = 128'h0; pr = 4'd0;
        ref_expand(nk, k);
        @(negedge clk);
        sel = s; key_c = k; start_c = 1'b1; ready_c = 1'b0;
        @(negedge clk);
        if (!hold) start_c = 1'b0;
        chk("busy_after_start", 128'(cur_busy), 128'd1);
        while (!fin && cyc < 400) begin
            if (cur_done) begin
                chk("rounds_before_done", 128'(exp_r), 128'(nr + 1));
                chk("busy_in_done_cycle", 128'(cur_busy), 128'd0);
                done_cyc = cyc;
                fin = 1'b1;
            end else begin
                chk("busy_during", 128'(cur_busy), 128'd1);
                if (cyc == poke) begin
                    start_c = 1'b1; key_c = ~k;
                end else if (!hold) begin
                    start_c = 1'b0; key_c = k;
                end
                ready_c = ($urandom_range(99) < pct);
                if (cur_valid) begin
                    if (stalled) begin
                        chk("stall_data", cur_data, pd);
                        chk("stall_round", 128'(cur_round), 128'(pr));
                    end
                    if (ready_c) begin
                        chk("rk_round", 128'(cur_round), 128'(exp_r));
                        chk("rk_data", cur_data, ref_rk(exp_r));
                        if (exp_r < 15) cap[exp_r] = cur_data;
                        if (first_cyc < 0) first_cyc = cyc;
                        exp_r++;
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1; stalls++;
                        pd = cur_data; pr = cur_round;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) chk("done_timeout", 128'd0, 128'd1);
    endtask

    typedef struct {
        int           s;
        logic [255:0] key;
        int           round;
        logic [127:0] exp;
    } vec_t;

    initial begin : main
        vec_t vt [7];
        int dc, fc, st, ks, n;
        logic [255:0] k, mask_hi;
        bit quiet;

        vt[0] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        vt[1] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1, 128'ha0fafe1788542cb123a339392a6c7605};
        vt[2] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vt[3] = '{1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 12,
                  128'he98ba06f448c773c8ecc720401002202};
        vt[4] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 0,
                  128'h603deb1015ca71be2b73aef0857d7781};
        vt[5] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1,
                  128'h1f352c073b6108d72d9810a30914dff4};
        vt[6] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 14,
                  128'hfe4890d1e6188d0b046df344706c631e};

        build_sbox();
        reset_n = 1'b0; start_c = 1'b0; ready_c = 1'b0; key_c = 256'h0; sel = 0;
        repeat (3) @(negedge clk);
        chk("reset_128", {b128, v128, dn128, r128, d128}, 128'h0);
        chk("reset_192", {b192, v192, dn192, r192, d192}, 128'h0);
        chk("reset_256", {b256, v256, dn256, r256, d256}, 128'h0);
        reset_n = 1'b1;

        // Known-answer vectors; bits above the key size are filled with noise.
        for (int i = 0; i < 7; i++) begin
            ks = 128 + 64 * vt[i].s;
            mask_hi = ~((256'h1 << ks) - 256'h1);
            k = vt[i].key | (rnd256() & mask_hi);
            run_exp(vt[i].s, k, 100, -1, 1'b0, dc, fc, st);
            chk("kat_round_key", cap[vt[i].round], vt[i].exp);
            chk("kat_first_valid", 128'(fc), 128'd4);
            chk("kat_done_cycle", 128'(dc), 128'(ks / 8 + 29));
        end

        // Random keys with backpressure: each stall costs exactly one cycle.
        for (int i = 0; i < 6; i++) begin
            k = rnd256();
            run_exp(i % 3, k, (i % 3 == 0) ? 30 : 50, -1, 1'b0, dc, fc, st);
            chk("bp_done_cycle", 128'(dc), 128'(4 * ((i % 3) * 2 + 11) + 1 + st));
        end

        // start pulsed mid-expansion with a different key is ignored.
        k = rnd256();
        run_exp(0, k, 100, 10, 1'b0, dc, fc, st);
        chk("poke_done_cycle", 128'(dc), 128'd45);

        // Reset while round 5 is presented aborts with no done.
        k = rnd256();
        @(negedge clk);
        sel = 0; key_c = k; start_c = 1'b1; ready_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        n = 0;
        while (!(v128 && r128 == 4'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_round5", 128'(n < 100), 128'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", {b128, v128, dn128, r128, d128}, 128'h0);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (dn128 || b128 || v128) quiet = 1'b0;
        end
        chk("no_done_after_abort", 128'(quiet), 128'd1);
        run_exp(0, k, 100, -1, 1'b0, dc, fc, st);
        chk("restart_done_cycle", 128'(dc), 128'd45);

        // start held high: the next expansion is accepted in the done cycle.
        k = rnd256();
        run_exp(0, k, 100, -1, 1'b1, dc, fc, st);
        chk("b2b_done_cycle", 128'(dc), 128'd45);
        @(negedge clk);
        chk("b2b_busy_again", 128'(b128), 128'd1);
        repeat (3) @(negedge clk);
        chk("b2b_not_yet_valid", 128'(v128), 128'd0);
        @(negedge clk);
        chk("b2b_round0_valid", {v128, r128}, {1'b1, 4'd0});
        chk("b2b_round0_data", d128, ref_rk(0));
        start_c = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
